// File: rtl/pin_entry.sv
// Purpose : ATM keypad front end; packs BCD keys into a 16-bit PIN, offers it downstream, tracks auth failures/lockout.
// Latency : key sampled at posedge N updates pin_out/digit_count at N; enter at N raises pin_valid at N; all outputs registered.
// Backpress: pin_valid and pin_out hold steady in PRESENT until pin_ready; keys ignored meanwhile; card removal aborts the offer.
//
// Ports:
//   clk, rst          clock (posedge) and asynchronous active-low reset
//   card_in           level, card inserted
//   key_valid/key_code  one-cycle key strobe; 0-9 digit, A clear, B backspace, C enter, D-F ignored
//   pin_ready         downstream accepts pin_out this cycle
//   auth_done/auth_ok verdict strobe and verdict
//   pin_out/pin_valid packed BCD PIN (first digit in [15:12]) and its valid flag
//   digit_count       digits buffered (0-4)
//   fail_count        consecutive failed authentications for this card
//   session_active    PIN accepted, held until card removal
//   locked            card locked, held until rst
//   timeout           one-cycle pulse when an idle entry is abandoned
//
// TIMEOUT_CYCLES must be >= 2; MAX_TRIES must be 1..7.
module pin_entry #(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int MAX_TRIES      = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        card_in,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic        pin_ready,
  input  logic        auth_done,
  input  logic        auth_ok,
  output logic [15:0] pin_out,
  output logic        pin_valid,
  output logic [2:0]  digit_count,
  output logic [2:0]  fail_count,
  output logic        session_active,
  output logic        locked,
  output logic        timeout
);

  localparam int              TIMER_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]      FAIL_LIMIT = 3'(MAX_TRIES);

  localparam logic [3:0] KEY_CLEAR = 4'hA;
  localparam logic [3:0] KEY_BKSP  = 4'hB;
  localparam logic [3:0] KEY_ENTER = 4'hC;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    PRESENT,
    WAIT_AUTH,
    DONE,
    LOCKED
  } state_t;

  state_t               state;
  logic [TIMER_W-1:0]   timer;

  logic                 key_is_digit;
  logic [2:0]           fail_next;

  assign key_is_digit = (key_code <= 4'd9);
  assign fail_next    = fail_count + 3'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      timer          <= '0;
      pin_out        <= 16'h0000;
      pin_valid      <= 1'b0;
      digit_count    <= 3'd0;
      fail_count     <= 3'd0;
      session_active <= 1'b0;
      locked         <= 1'b0;
      timeout        <= 1'b0;
    end else begin
      timeout <= 1'b0;

      // Card removal outranks everything except a lockout, which keeps the card.
      if (state != LOCKED && !card_in) begin
        state          <= IDLE;
        timer          <= '0;
        pin_out        <= 16'h0000;
        pin_valid      <= 1'b0;
        digit_count    <= 3'd0;
        fail_count     <= 3'd0;
        session_active <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            // card_in is necessarily high here (removal branch handles low).
            state       <= COLLECT;
            timer       <= '0;
            pin_out     <= 16'h0000;
            digit_count <= 3'd0;
          end

          COLLECT: begin
            if (key_valid) begin
              // Any strobe, even an ignored code, counts as activity.
              timer <= '0;
              if (key_is_digit) begin
                if (digit_count < 3'd4) begin
                  pin_out     <= {pin_out[11:0], key_code};
                  digit_count <= digit_count + 3'd1;
                end
              end else if (key_code == KEY_BKSP) begin
                if (digit_count != 3'd0) begin
                  pin_out     <= {4'h0, pin_out[15:4]};
                  digit_count <= digit_count - 3'd1;
                end
              end else if (key_code == KEY_CLEAR) begin
                pin_out     <= 16'h0000;
                digit_count <= 3'd0;
              end else if (key_code == KEY_ENTER) begin
                if (digit_count == 3'd4) begin
                  state     <= PRESENT;
                  pin_valid <= 1'b1;
                end
              end
            end else if (timer == TIMER_LAST) begin
              // Last idle cycle: abandon the partial entry but keep collecting.
              timeout     <= 1'b1;
              timer       <= '0;
              pin_out     <= 16'h0000;
              digit_count <= 3'd0;
            end else begin
              timer <= timer + TIMER_W'(1);
            end
          end

          PRESENT: begin
            // pin_valid is high throughout this state.
            if (pin_ready) begin
              state     <= WAIT_AUTH;
              pin_valid <= 1'b0;
            end
          end

          WAIT_AUTH: begin
            if (auth_done) begin
              if (auth_ok) begin
                state          <= DONE;
                session_active <= 1'b1;
                fail_count     <= 3'd0;
              end else begin
                fail_count  <= fail_next;
                pin_out     <= 16'h0000;
                digit_count <= 3'd0;
                timer       <= '0;
                if (fail_next == FAIL_LIMIT) begin
                  state  <= LOCKED;
                  locked <= 1'b1;
                end else begin
                  state <= COLLECT;
                end
              end
            end
          end

          DONE: begin
            state <= DONE;
          end

          LOCKED: begin
            state <= LOCKED;
          end

          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pin_entry.sv
module tb_pin_entry;

  logic        clk = 1'b0;
  logic        rst;
  logic        card_in;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        pin_ready;
  logic        auth_done;
  logic        auth_ok;
  logic [15:0] pin_out;
  logic        pin_valid;
  logic [2:0]  digit_count;
  logic [2:0]  fail_count;
  logic        session_active;
  logic        locked;
  logic        timeout;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  pin_entry #(
    .TIMEOUT_CYCLES(8),
    .MAX_TRIES     (3)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .card_in       (card_in),
    .key_valid     (key_valid),
    .key_code      (key_code),
    .pin_ready     (pin_ready),
    .auth_done     (auth_done),
    .auth_ok       (auth_ok),
    .pin_out       (pin_out),
    .pin_valid     (pin_valid),
    .digit_count   (digit_count),
    .fail_count    (fail_count),
    .session_active(session_active),
    .locked        (locked),
    .timeout       (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] k);
    key_valid = 1'b1;
    key_code  = k;
    tick();
    key_valid = 1'b0;
    key_code  = 4'h0;
  endtask

  // Four digits, enter with ready high, one handshake, then a verdict.
  task automatic submit(input logic [15:0] pin, input logic ok);
    for (int i = 3; i >= 0; i--) press(pin[i*4 +: 4]);
    exp_q.push_back(pin);
    pin_ready = 1'b1;
    press(4'hC);
    tick();
    pin_ready = 1'b0;
    auth_done = 1'b1;
    auth_ok   = ok;
    tick();
    auth_done = 1'b0;
    auth_ok   = 1'b0;
  endtask

  // Scoreboard: every completed handshake must match the next queued PIN.
  always @(negedge clk) begin
    if (rst === 1'b1 && card_in === 1'b1 && pin_valid === 1'b1 && pin_ready === 1'b1) begin
      check("handshake_expected", 16'(exp_q.size() != 0), 16'd1);
      if (exp_q.size() != 0) check("handshake_pin", pin_out, exp_q.pop_front());
    end
  end

  initial begin
    card_in   = 1'b0;
    key_valid = 1'b0;
    key_code  = 4'h0;
    pin_ready = 1'b0;
    auth_done = 1'b0;
    auth_ok   = 1'b0;
    rst       = 1'b1;
    #1 rst    = 1'b0;
    repeat (2) tick();

    // Reset state
    check("rst_pin_out", pin_out, 16'h0000);
    check("rst_pin_valid", 16'(pin_valid), 16'd0);
    check("rst_digit_count", 16'(digit_count), 16'd0);
    check("rst_fail_count", 16'(fail_count), 16'd0);
    check("rst_session", 16'(session_active), 16'd0);
    check("rst_locked", 16'(locked), 16'd0);
    check("rst_timeout", 16'(timeout), 16'd0);
    rst = 1'b1;
    tick();

    // Basic accept
    card_in = 1'b1;
    tick();
    press(4'h1); press(4'h2); press(4'h3); press(4'h4);
    check("basic_pin_out", pin_out, 16'h1234);
    check("basic_count", 16'(digit_count), 16'd4);
    exp_q.push_back(16'h1234);
    pin_ready = 1'b1;
    press(4'hC);
    check("basic_valid_hi", 16'(pin_valid), 16'd1);
    tick();
    pin_ready = 1'b0;
    check("basic_valid_one_cycle", 16'(pin_valid), 16'd0);
    auth_done = 1'b1; auth_ok = 1'b1;
    tick();
    auth_done = 1'b0; auth_ok = 1'b0;
    check("basic_session", 16'(session_active), 16'd1);
    check("basic_fail_count", 16'(fail_count), 16'd0);
    card_in = 1'b0;
    tick();
    check("removal_session", 16'(session_active), 16'd0);

    // Edit path
    card_in = 1'b1;
    tick();
    press(4'h9); press(4'h8); press(4'hB);
    check("edit_bksp_pin", pin_out, 16'h0009);
    check("edit_bksp_count", 16'(digit_count), 16'd1);
    press(4'h7); press(4'h6); press(4'h5); press(4'h4);
    check("edit_pin_out", pin_out, 16'h9765);
    check("edit_count", 16'(digit_count), 16'd4);
    card_in = 1'b0;
    tick();
    check("edit_removed_pin", pin_out, 16'h0000);

    // Short enter, then backpressure
    card_in = 1'b1;
    tick();
    press(4'h1); press(4'h2); press(4'h3);
    press(4'hC);
    check("short_enter_valid", 16'(pin_valid), 16'd0);
    check("short_enter_count", 16'(digit_count), 16'd3);
    press(4'h4);
    exp_q.push_back(16'h1234);
    press(4'hC);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 16'(pin_valid), 16'd1);
      check("bp_pin_stable", pin_out, 16'h1234);
      if (i < 4) tick();
    end
    pin_ready = 1'b1;
    tick();
    pin_ready = 1'b0;
    check("bp_valid_drop", 16'(pin_valid), 16'd0);

    // Lockout
    auth_done = 1'b1; auth_ok = 1'b0;
    tick();
    auth_done = 1'b0;
    check("lock_fail1", 16'(fail_count), 16'd1);
    check("lock_fail1_count", 16'(digit_count), 16'd0);
    submit(16'h5678, 1'b0);
    check("lock_fail2", 16'(fail_count), 16'd2);
    check("lock_not_yet", 16'(locked), 16'd0);
    submit(16'h2468, 1'b0);
    check("lock_fail3", 16'(fail_count), 16'd3);
    check("lock_locked", 16'(locked), 16'd1);
    card_in = 1'b0;
    press(4'h5);
    repeat (3) tick();
    check("lock_after_removal", 16'(locked), 16'd1);
    check("lock_fail_held", 16'(fail_count), 16'd3);
    rst = 1'b0;
    #1;
    check("lock_async_rst", 16'(locked), 16'd0);
    check("lock_async_rst_fail", 16'(fail_count), 16'd0);
    tick();
    rst = 1'b1;
    tick();

    // Timeout (TIMEOUT_CYCLES = 8)
    card_in = 1'b1;
    tick();
    press(4'h1); press(4'h2);
    for (int k = 1; k <= 8; k++) begin
      tick();
      check("to_pulse", 16'(timeout), 16'(k == 8));
      check("to_count", 16'(digit_count), (k == 8) ? 16'd0 : 16'd2);
    end
    tick();
    check("to_pulse_one_cycle", 16'(timeout), 16'd0);
    press(4'h3);
    check("to_still_collect", 16'(digit_count), 16'd1);

    // Abort during PRESENT, after one failure
    press(4'hA);
    check("clear_count", 16'(digit_count), 16'd0);
    submit(16'h4321, 1'b0);
    check("abort_pre_fail", 16'(fail_count), 16'd1);
    press(4'h5); press(4'h6); press(4'h7); press(4'h8);
    press(4'hC);
    check("abort_present", 16'(pin_valid), 16'd1);
    card_in   = 1'b0;
    key_valid = 1'b1;
    key_code  = 4'h9;
    pin_ready = 1'b1;
    tick();
    key_valid = 1'b0;
    pin_ready = 1'b0;
    check("abort_valid", 16'(pin_valid), 16'd0);
    check("abort_pin_out", pin_out, 16'h0000);
    check("abort_fail", 16'(fail_count), 16'd0);
    check("abort_count", 16'(digit_count), 16'd0);
    press(4'h1);
    check("idle_ignores_keys", 16'(digit_count), 16'd0);

    // Asynchronous reset mid-COLLECT
    card_in = 1'b1;
    tick();
    press(4'h1); press(4'h2);
    check("mid_count", 16'(digit_count), 16'd2);
    rst = 1'b0;
    #1;
    check("mid_rst_count", 16'(digit_count), 16'd0);
    check("mid_rst_pin", pin_out, 16'h0000);
    tick();
    rst = 1'b1;
    tick();

    check("queue_drained", 16'(exp_q.size()), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pin_entry.md
# pin_entry

Keypad front end for the ATM controller. It collects BCD digits from the keypad and packs them into the 16-bit PIN word that the authenticator consumes. It hands that word downstream with a valid/ready handshake and waits for the authentication verdict. It also owns the per-card failed-attempt counter, inactivity timeout and card lockout, so the ATM state machine only ever sees complete, well-formed PIN submissions.

## Interface
- TIMEOUT_CYCLES, 1000: idle cycles allowed in COLLECT before the entry is abandoned (must be ≥2).
- MAX_TRIES, 3: consecutive failed authentications that lock the card (1–7).
- clk  in  1  clock; all logic on posedge.
- rst  in  1  reset, asynchronous, active-low.
- card_in  in  1  level; high while a card (account) is inserted.
- key_valid  in  1  one-cycle strobe; key_code is valid.
- key_code  in  4  0–9 digit, 4'hA clear, 4'hB backspace, 4'hC enter; 4'hD–4'hF ignored.
- pin_ready  in  1  downstream accepts pin_out this cycle.
- auth_done  in  1  one-cycle verdict strobe from the authenticator.
- auth_ok  in  1  verdict, sampled only with auth_done.
- pin_out  out  16  packed BCD; first digit in [15:12], last digit in [3:0].
- pin_valid  out  1  PIN offered downstream.
- digit_count  out  3  digits currently buffered, 0–4.
- fail_count  out  3  consecutive failures for this card.
- session_active  out  1  PIN accepted; high until card removed.
- locked  out  1  card locked.
- timeout  out  1  one-cycle pulse on inactivity abandon.

## Operation
- **States:** IDLE, COLLECT, PRESENT, WAIT_AUTH, DONE, LOCKED.
- **IDLE:**
  - card_in high → COLLECT with buffer, digit_count and timer at 0.
  - Keys are ignored.
- **COLLECT, digits:** a digit with digit_count<4 shifts in, pin_out = {pin_out[11:0], key_code}, and digit_count+1. A digit with digit_count=4 is ignored.
- **COLLECT, backspace:** pin_out = {4'h0, pin_out[15:4]} and digit_count−1. Ignored when digit_count=0.
- **COLLECT, clear:** pin_out=0 and digit_count=0.
- **COLLECT, enter:**
  - With digit_count=4 → PRESENT.
  - Otherwise ignored, but the timer still restarts.
- **COLLECT, timer:**
  - Any key_valid, including ignored codes, restarts the timer to 0.
  - Otherwise the timer increments each cycle.
  - On the cycle it equals TIMEOUT_CYCLES−1: pulse timeout, clear the buffer and digit_count, stay in COLLECT.
- **PRESENT:**
  - pin_valid=1 and pin_out is held stable.
  - The transfer completes on the posedge where pin_valid and pin_ready are both 1 → WAIT_AUTH, pin_valid=0.
  - Keys are ignored.
- **WAIT_AUTH:** keys are ignored and there is no timeout.
  - auth_done with auth_ok=1 → DONE, fail_count=0.
  - auth_done with auth_ok=0 → fail_count+1, buffer and digit_count cleared. If the new fail_count=MAX_TRIES → LOCKED, otherwise → COLLECT.
- **DONE:** session_active=1; keys are ignored.
- **LOCKED:**
  - locked=1.
  - Ignores every input, including card removal; the card is retained.
  - Only rst exits.
- **Card removal:** card_in low in any state except LOCKED → IDLE on the next posedge. It clears the buffer, digit_count, fail_count, session_active and pin_valid, and aborts an in-flight handshake.
- **Precedence per cycle:** rst > card removal > auth_done > key_valid > timer.
- auth_done outside WAIT_AUTH is ignored.

## Timing
- **Reset values:** all outputs 0 (pin_out=16'h0000, pin_valid=0, digit_count=0, fail_count=0, session_active=0, locked=0, timeout=0); state=IDLE.
- **Key response:** key_valid sampled at posedge N → pin_out and digit_count update at N (visible after N).
- **Enter latency:** enter at posedge N → pin_valid high from N. The earliest handshake is N+1.
- **auth_done latency:** auth_done at posedge M → session_active, locked or the COLLECT re-entry are visible after M.
- **Timeout:** the timeout pulse occurs TIMEOUT_CYCLES cycles after the last key in COLLECT.
- All outputs are registered; no combinational input-to-output paths.

## Test plan
- **Basic accept:**
  - Stimulus: card_in=1, keys 1,2,3,4, enter, pin_ready=1, auth_done with auth_ok=1.
  - Required: pin_out=16'h1234 with pin_valid for exactly 1 cycle; then session_active=1 and fail_count=0.
- **Edit path:**
  - Stimulus: keys 9,8,backspace,7,6,5, digit 4 (fifth digit), enter.
  - Required: pin_out=16'h9765 and digit_count=4. The fifth digit is ignored.
- **Backpressure and short enter:**
  - Stimulus: enter after 3 digits, then a 4th digit and enter with pin_ready held low for 5 cycles.
  - Required: the first enter is ignored; pin_valid stays high and pin_out stays stable until pin_ready rises.
- **Lockout:**
  - Stimulus: three PIN submissions each answered with auth_ok=0, then card_in=0.
  - Required: fail_count steps 1,2,3, then locked=1 and stays 1 after card removal until rst.
- **Timeout:**
  - Stimulus: TIMEOUT_CYCLES=8; enter 2 digits then idle.
  - Required: the timeout pulse occurs exactly 8 cycles after the last key; digit_count=0 and state remains COLLECT.
- **Abort:**
  - Stimulus: pull card_in low during PRESENT, with key_valid on the same cycle.
  - Required: IDLE next cycle with pin_valid=0, pin_out=0 and fail_count=0.
  - Also: assert rst mid-COLLECT → all outputs return to 0 asynchronously.
